i2c_slave_controller: RTL
=========================

I2C_SLAVE_CONTROLLER -- requirements
Module: i2c_slave_controller

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth applied to scl_i and sda_i.
REQ-002 SHALL have ports:
- i2c_core_clock_i  in  1  sole clock.
- reset_bit_i  in  1  reset, asynchronous and active-low.
- scl_i  in  1  bus SCL, raw.
- sda_i  in  1  bus SDA, raw.
- own_addr_i  in  7  slave address.
- tx_data_i  in  8  byte to transmit on a read.
- tx_valid_i  in  1  tx_data_i holds a valid byte.
- sda_o  out  1  open-drain drive: 0 = pull low, 1 = release.
- tx_ready_o  out  1  one-cycle pulse; tx_data_i consumed.
- rx_data_o  out  8  last received byte.
- rx_valid_o  out  1  one-cycle pulse; rx_data_o updated.
- addr_match_o  out  1  high while addressed, from address ACK until STOP, START, master NACK or mismatch.
- rw_o  out  1  R/W bit of the current transfer (1 = read).
- busy_o  out  1  high between START and STOP.
- underrun_o  out  1  one-cycle pulse; read byte needed with tx_valid_i low.

Function
REQ-003 SHALL sample scl_i and sda_i through SYNC_STAGES flops, then detect edges against one further registered copy.
REQ-004 SHALL flag START on synced SDA falling while synced SCL high; STOP on synced SDA rising while synced SCL high.
REQ-005 SHALL sample SDA only on synced SCL rising edges and change sda_o only on the cycle after a synced SCL falling edge.
REQ-006 SHALL implement states IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK and IGNORE.
REQ-007 SHALL, on START from any state (including repeated START), go to ADDR with bit counter = 7 and sda_o = 1.
REQ-008 SHALL, on STOP from any state, go to IDLE with sda_o = 1 and busy_o = 0.
REQ-009 SHALL shift 8 bits MSB-first in ADDR, and on the 8th rising edge compare bits [7:1] with own_addr_i.
- On match, latch rw_o = bit0 and go to ADDR_ACK.
- Otherwise go to IGNORE.
REQ-010 SHALL treat address 0x00 (general call) as mismatch.
REQ-011 SHALL, in ADDR_ACK, drive sda_o = 0 from the falling edge after bit 8 through the next falling edge.
- If rw_o = 0, next state is RX_DATA.
- If rw_o = 1, next state is TX_DATA, loading the first byte on that falling edge.
REQ-012 SHALL, in RX_DATA, release SDA and shift 8 bits.
- On the 8th rising edge, update rx_data_o and pulse rx_valid_o on the next cycle.
- Then go to RX_ACK, driving 0 for one SCL period, then return to RX_DATA.
REQ-013 SHALL load the transmit shift register on entry to each TX_DATA byte.
- If tx_valid_i = 1, load tx_data_i and pulse tx_ready_o.
- Otherwise load 0xFF and pulse underrun_o.
REQ-014 SHALL drive each TX bit MSB-first on falling edges, then release SDA on the falling edge after bit 8 and enter TX_ACK.
REQ-015 SHALL sample the master acknowledge on the TX_ACK rising edge.
- 0 (ACK): go to TX_DATA and load the next byte.
- 1 (NACK): go to IGNORE and clear addr_match_o.
REQ-016 SHALL, in IGNORE, hold sda_o = 1 and wait for START or STOP.
REQ-017 SHALL give START/STOP priority over a coincident SCL edge in the same cycle.
REQ-018 SHALL use a 3-bit bit counter that wraps 0 -> 7 at each byte boundary and never indexes outside 7..0.

Reset
REQ-019 SHALL asynchronously force the following while reset_bit_i = 0:
- state = IDLE, sda_o = 1, rx_data_o = 0x00.
- tx_ready_o, rx_valid_o, underrun_o, addr_match_o, rw_o, busy_o = 0.
- synchronizers = 1.
REQ-020 SHALL, on reset release mid-transfer, stay in IDLE until the next START.

Structure
REQ-021 SHALL place the state encoding, ACK = 0 / NACK = 1 constants and the default fill byte 0xFF in shared package i2c_pkg.
REQ-022 SHALL isolate the synchronizer plus START/STOP/SCL-edge detection in sub-module i2c_bus_monitor.

Verification
REQ-023 Write: own_addr 0x50, master sends START, 0xA0, 0x3C, STOP -> two ACKs (sda_o = 0), rx_data_o = 0x3C with one rx_valid_o pulse, busy_o low after STOP.
REQ-024 Read: START, 0xA1, tx_data_i 0x96 then 0x5A, master ACK then NACK -> SDA bits 10010110 then 01011010, two tx_ready_o pulses, IGNORE after NACK.
REQ-025 Mismatch: START, 0xA2, 0x11 -> sda_o stays 1 throughout, no rx_valid_o, addr_match_o = 0.
REQ-026 Repeated START: write 0xA0, 0x07, then Sr, 0xA1 -> rw_o changes 0 -> 1, ACK on both addresses, first read byte loaded.
REQ-027 Underrun plus abort: read with tx_valid_i = 0 -> 0xFF sent and one underrun_o pulse. Then STOP after 3 bits of the next byte -> IDLE, sda_o = 1.
REQ-028 Reset mid-byte: assert reset_bit_i during RX_DATA bit 4 -> all outputs at reset values immediately; no response until a new START.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave controller: state encoding,
// acknowledge levels, the underrun fill byte and the address-match rule.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_RX_DATA  = 3'd3,
    ST_RX_ACK   = 3'd4,
    ST_TX_DATA  = 3'd5,
    ST_TX_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } i2c_state_e;

  localparam logic       ACK       = 1'b0;
  localparam logic       NACK      = 1'b1;
  localparam logic [7:0] FILL_BYTE = 8'hFF;
  localparam logic [2:0] BIT_MSB   = 3'd7;

  // The general-call address never selects this slave.
  function automatic logic addr_hit(input logic [6:0] rx_addr, input logic [6:0] own_addr);
    return (rx_addr == own_addr) && (rx_addr != 7'h00);
  endfunction

endpackage

// File: rtl/i2c_slave_controller_if.sv
// Raw two-wire bus as seen by the slave: the master side drives SCL/SDA,
// the slave side only observes them (its open-drain drive is a separate port).
interface i2c_slave_controller_if;
  logic scl;
  logic sda;

  modport master (output scl, output sda);
  modport slave  (input scl, input sda);
endinterface

// File: rtl/i2c_bus_monitor.sv
// Synchronises raw SCL/SDA and decodes SCL edges plus START/STOP conditions
// against one further registered copy of the synchronised lines.
module i2c_bus_monitor
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  i2c_slave_controller_if.slave bus,
  output logic                  sda_o,
  output logic                  scl_rise_o,
  output logic                  scl_fall_o,
  output logic                  start_o,
  output logic                  stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // Synchroniser chains and the edge-reference copy; idle bus level is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= (scl_sync_q << 1) | SYNC_STAGES'(bus.scl);
      sda_sync_q <= (sda_sync_q << 1) | SYNC_STAGES'(bus.sda);
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_controller.sv
// 7-bit I2C slave: address match, byte receive with ACK, byte transmit with
// master ACK/NACK, underrun fill and START/STOP recovery from any state.
module i2c_slave_controller
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i2c_core_clock_i,
  input  logic       reset_bit_i,
  input  logic       scl_i,
  input  logic       sda_i,
  input  logic [6:0] own_addr_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       sda_o,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       addr_match_o,
  output logic       rw_o,
  output logic       busy_o,
  output logic       underrun_o
);

  i2c_slave_controller_if bus_if ();

  assign bus_if.scl = scl_i;
  assign bus_if.sda = sda_i;

  logic sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_bus_monitor (
    .clk_i      (i2c_core_clock_i),
    .rst_ni     (reset_bit_i),
    .bus        (bus_if),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise_s),
    .scl_fall_o (scl_fall_s),
    .start_o    (start_s),
    .stop_o     (stop_s)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_q, sda_d;
  logic       rw_q, rw_d;
  logic       match_q, match_d;
  logic       busy_q, busy_d;
  logic       load_pend_q, load_pend_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_ready_q, tx_ready_d;
  logic       underrun_q, underrun_d;
  logic [7:0] load_byte_s;
  logic       hit_s;

  assign load_byte_s = tx_valid_i ? tx_data_i : FILL_BYTE;
  assign hit_s       = addr_hit(shift_q, own_addr_i);

  // State register.
  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
    if (!reset_bit_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; bus conditions override any coincident SCL edge.
  always_comb begin
    state_d = state_q;
    if (stop_s) begin
      state_d = ST_IDLE;
    end else if (start_s) begin
      state_d = ST_ADDR;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_IDLE;
        ST_IGNORE:   state_d = ST_IGNORE;
        ST_ADDR: begin
          if (scl_rise_s && (bit_cnt_q == 3'd0)) state_d = hit_s ? ST_ADDR_ACK : ST_IGNORE;
          else                                   state_d = ST_ADDR;
        end
        ST_ADDR_ACK: begin
          if (scl_fall_s && !sda_q) state_d = rw_q ? ST_TX_DATA : ST_RX_DATA;
          else                      state_d = ST_ADDR_ACK;
        end
        ST_RX_DATA: begin
          if (scl_rise_s && (bit_cnt_q == 3'd0)) state_d = ST_RX_ACK;
          else                                   state_d = ST_RX_DATA;
        end
        ST_RX_ACK: begin
          if (scl_fall_s && !sda_q) state_d = ST_RX_DATA;
          else                      state_d = ST_RX_ACK;
        end
        ST_TX_DATA: begin
          if (scl_fall_s && !load_pend_q && (bit_cnt_q == 3'd0)) state_d = ST_TX_ACK;
          else                                                   state_d = ST_TX_DATA;
        end
        ST_TX_ACK: begin
          if (scl_rise_s) state_d = (sda_s == NACK) ? ST_IGNORE : ST_TX_DATA;
          else            state_d = ST_TX_ACK;
        end
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath next values; sda only moves on SCL falling edges.
  always_comb begin
    sda_d       = sda_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rw_d        = rw_q;
    match_d     = match_q;
    busy_d      = busy_q;
    load_pend_d = load_pend_q;
    rx_valid_d  = 1'b0;
    tx_ready_d  = 1'b0;
    underrun_d  = 1'b0;
    if (stop_s) begin
      sda_d       = 1'b1;
      busy_d      = 1'b0;
      match_d     = 1'b0;
      load_pend_d = 1'b0;
    end else if (start_s) begin
      sda_d       = 1'b1;
      busy_d      = 1'b1;
      match_d     = 1'b0;
      load_pend_d = 1'b0;
      bit_cnt_d   = BIT_MSB;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_d   = {shift_q[5:0], sda_s};
            bit_cnt_d = bit_cnt_q - 3'd1;
            if ((bit_cnt_q == 3'd0) && hit_s) begin
              rw_d    = sda_s;
              match_d = 1'b1;
            end else begin
              match_d = 1'b0;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        // sda_q doubles as the ACK phase: high before the ACK slot, low during it.
        ST_ADDR_ACK, ST_RX_ACK: begin
          if (scl_fall_s && sda_q) begin
            sda_d = ACK;
          end else if (scl_fall_s && (state_q == ST_ADDR_ACK) && rw_q) begin
            sda_d      = load_byte_s[7];
            shift_d    = load_byte_s[6:0];
            bit_cnt_d  = BIT_MSB;
            tx_ready_d = tx_valid_i;
            underrun_d = ~tx_valid_i;
          end else if (scl_fall_s) begin
            sda_d     = 1'b1;
            bit_cnt_d = BIT_MSB;
          end else begin
            sda_d = sda_q;
          end
        end
        ST_RX_DATA: begin
          if (scl_rise_s) begin
            shift_d   = {shift_q[5:0], sda_s};
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              rx_data_d  = {shift_q, sda_s};
              rx_valid_d = 1'b1;
            end else begin
              rx_valid_d = 1'b0;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        ST_TX_DATA: begin
          if (scl_fall_s && load_pend_q) begin
            sda_d       = load_byte_s[7];
            shift_d     = load_byte_s[6:0];
            bit_cnt_d   = BIT_MSB;
            tx_ready_d  = tx_valid_i;
            underrun_d  = ~tx_valid_i;
            load_pend_d = 1'b0;
          end else if (scl_fall_s && (bit_cnt_q == 3'd0)) begin
            sda_d     = 1'b1;
            bit_cnt_d = BIT_MSB;
          end else if (scl_fall_s) begin
            sda_d     = shift_q[6];
            shift_d   = {shift_q[5:0], 1'b1};
            bit_cnt_d = bit_cnt_q - 3'd1;
          end else begin
            sda_d = sda_q;
          end
        end
        ST_TX_ACK: begin
          if (scl_rise_s && (sda_s == NACK)) begin
            match_d = 1'b0;
          end else if (scl_rise_s) begin
            load_pend_d = 1'b1;
          end else begin
            load_pend_d = load_pend_q;
          end
        end
        ST_IDLE, ST_IGNORE: sda_d = 1'b1;
        default:            sda_d = 1'b1;
      endcase
    end
  end

  // Registered outputs and datapath.
  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
    if (!reset_bit_i) begin
      sda_q       <= 1'b1;
      bit_cnt_q   <= BIT_MSB;
      shift_q     <= 7'h00;
      rx_data_q   <= 8'h00;
      rw_q        <= 1'b0;
      match_q     <= 1'b0;
      busy_q      <= 1'b0;
      load_pend_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_ready_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      sda_q       <= sda_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rw_q        <= rw_d;
      match_q     <= match_d;
      busy_q      <= busy_d;
      load_pend_q <= load_pend_d;
      rx_valid_q  <= rx_valid_d;
      tx_ready_q  <= tx_ready_d;
      underrun_q  <= underrun_d;
    end
  end

  assign sda_o        = sda_q;
  assign tx_ready_o   = tx_ready_q;
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign addr_match_o = match_q;
  assign rw_o         = rw_q;
  assign busy_o       = busy_q;
  assign underrun_o   = underrun_q;

endmodule
